calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 178 +++++++++++++++++
 tb/tb_calc_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Sequencer for y = sin(angle) * a/(a+b+c) using external divider, sine and multiplier units.
// Captures operands, shifts in a 10-bit serial angle, then scales the sine by the quotient.
module calc_sequencer #(
  parameter int unsigned MUL_LAT     = 2,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic [11:0] c,
  input  logic        e,
  output logic        div_en,
  output logic [25:0] div_dividend,
  output logic [13:0] div_divisor,
  input  logic        div_ok,
  input  logic [25:0] div_quotient,
  output logic [9:0]  sin_in,
  input  logic [12:0] sin_out,
  input  logic        sin_sign,
  output logic        mul_en,
  output logic [25:0] mul_a,
  output logic [12:0] mul_b,
  input  logic [38:0] mul_product,
  output logic [13:0] y,
  output logic        y_valid,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, DIV, MUL, DONE, ERR} state_t;

  state_t      state_q;
  logic [11:0] a_q, b_q, c_q;
  logic [9:0]  angle_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  div_cnt_q;
  logic [3:0]  mul_cnt_q;
  logic [25:0] q_q;
  logic        q_vld_q;
  logic [12:0] s_q;
  logic        sgn_q;
  logic [13:0] y_q;
  logic        y_valid_q, err_q, busy_q, div_en_q, mul_en_q;

  logic [13:0] in_sum_d;
  logic        bits_last_d;
  logic        div_exit_d;
  logic        div_tmo_d;
  logic [12:0] p_d;
  logic [12:0] mag_d;
  logic [13:0] y_d;
  logic        unused_prod;

  assign in_sum_d     = {2'b00, a} + {2'b00, b} + {2'b00, c};
  assign div_dividend = {a_q, 14'b0};
  assign div_divisor  = {2'b00, a_q} + {2'b00, b_q} + {2'b00, c_q};
  assign sin_in       = angle_q;
  assign mul_a        = q_q;
  assign mul_b        = s_q;

  // The 10th angle bit shifts in on the same edge that leaves DIV, so the
  // exit is allowed once the counter shows 9 bits already taken.
  assign bits_last_d = (bit_cnt_q >= 4'd9);
  assign div_exit_d  = bits_last_d && (q_vld_q || div_ok);
  assign div_tmo_d   = !q_vld_q && !div_ok &&
                       (({1'b0, div_cnt_q} + 9'd1) == 9'(DIV_TIMEOUT));

  assign p_d         = mul_product[26:14];
  assign mag_d       = sgn_q ? (~p_d + 13'd1) : p_d;
  assign y_d         = {sgn_q, mag_d};
  assign unused_prod = ^{mul_product[38:27], mul_product[13:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      angle_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      mul_cnt_q <= '0;
      q_q       <= '0;
      q_vld_q   <= 1'b0;
      s_q       <= '0;
      sgn_q     <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      div_en_q  <= 1'b0;
      mul_en_q  <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            c_q       <= c;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            q_vld_q   <= 1'b0;
            busy_q    <= 1'b1;
            if (in_sum_d == '0) begin
              state_q   <= ERR;
              y_q       <= '0;
              y_valid_q <= 1'b1;
              err_q     <= 1'b1;
            end else begin
              state_q  <= DIV;
              div_en_q <= 1'b1;
            end
          end
        end
        DIV: begin
          if (bit_cnt_q < 4'd10) begin
            angle_q   <= {angle_q[8:0], e};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
          if (!q_vld_q) begin
            div_cnt_q <= div_cnt_q + 8'd1;
            if (div_ok) begin
              q_q      <= div_quotient;
              q_vld_q  <= 1'b1;
              div_en_q <= 1'b0;
            end
          end
          if (div_exit_d) begin
            state_q   <= MUL;
            s_q       <= sin_out;
            sgn_q     <= sin_sign;
            mul_en_q  <= 1'b1;
            mul_cnt_q <= '0;
            div_en_q  <= 1'b0;
          end else if (div_tmo_d) begin
            state_q   <= ERR;
            y_q       <= '0;
            y_valid_q <= 1'b1;
            err_q     <= 1'b1;
            div_en_q  <= 1'b0;
          end
        end
        MUL: begin
          if (mul_cnt_q == 4'(MUL_LAT - 1)) begin
            state_q   <= DONE;
            y_q       <= y_d;
            y_valid_q <= 1'b1;
            mul_en_q  <= 1'b0;
          end else begin
            mul_cnt_q <= mul_cnt_q + 4'd1;
          end
        end
        DONE, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          div_en_q <= 1'b0;
          mul_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign div_en  = div_en_q;
  assign mul_en  = mul_en_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with simple divider/sine/multiplier stubs.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, e;
  logic [11:0] a, b, c;
  logic        div_en, div_ok;
  logic [25:0] div_dividend, div_quotient;
  logic [13:0] div_divisor;
  logic [9:0]  sin_in;
  logic [12:0] sin_out;
  logic        sin_sign;
  logic        mul_en;
  logic [25:0] mul_a;
  logic [12:0] mul_b;
  logic [38:0] mul_product;
  logic [13:0] y;
  logic        y_valid, err, busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned cnt;
  logic [9:0]  ebits;

  calc_sequencer #(.MUL_LAT(2), .DIV_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .e(e),
    .div_en(div_en), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ok(div_ok), .div_quotient(div_quotient),
    .sin_in(sin_in), .sin_out(sin_out), .sin_sign(sin_sign),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .y(y), .y_valid(y_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mul_product = {13'b0, mul_a} * {26'b0, mul_b};

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic begin_op(input logic [11:0] av, input logic [11:0] bv, input logic [11:0] cv);
    a = av; b = bv; c = cv;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_cycle(input int unsigned n);
    while (cyc < n) step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; e = 1'b0; a = '0; b = '0; c = '0;
    div_ok = 1'b0; div_quotient = 26'd5461; sin_out = 13'd4096; sin_sign = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_y", y, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_en", {div_en, mul_en, err}, 0);

    // Nominal positive result, early div_ok must not shorten DIV
    begin_op(12'd100, 12'd100, 12'd100);
    chk("t1_busy", busy, 1);
    chk("t1_diven", div_en, 1);
    chk("t1_divisor", div_divisor, 300);
    chk("t1_dividend", div_dividend, 26'd1638400);
    wait_cycle(5);
    div_ok = 1'b1;
    step();
    div_ok = 1'b0;
    chk("t1_diven_off", div_en, 0);
    wait_cycle(10);
    chk("t1_mulen_c10", mul_en, 0);
    step();
    chk("t1_mulen_c11", mul_en, 1);
    chk("t1_mulb", mul_b, 4096);
    chk("t1_mula", mul_a, 5461);
    step();
    chk("t1_mulen_c12", mul_en, 1);
    chk("t1_yv_c12", y_valid, 0);
    step();
    chk("t1_yv_c13", y_valid, 1);
    chk("t1_y", y, 14'h0555);
    chk("t1_err", err, 0);
    chk("t1_mulen_c13", mul_en, 0);
    step();
    chk("t1_yv_c14", y_valid, 0);
    chk("t1_busy_c14", busy, 0);
    chk("t1_yhold", y, 14'h0555);

    // Negative sine
    sin_sign = 1'b1;
    begin_op(12'd100, 12'd100, 12'd100);
    wait_cycle(5);
    div_ok = 1'b1;
    step();
    div_ok = 1'b0;
    wait_cycle(13);
    chk("t2_yv", y_valid, 1);
    chk("t2_y", y, 14'h3AAB);
    sin_sign = 1'b0;
    step();

    // Zero operand sum
    begin_op(12'd0, 12'd0, 12'd0);
    chk("t3_yv", y_valid, 1);
    chk("t3_err", err, 1);
    chk("t3_y", y, 0);
    chk("t3_diven", div_en, 0);
    step();
    chk("t3_busy", busy, 0);
    chk("t3_yv_off", y_valid, 0);

    // Divider timeout
    begin_op(12'd1, 12'd0, 12'd0);
    cnt = 0;
    while (cyc <= 70 && !y_valid) begin
      if (div_en) cnt++;
      step();
    end
    chk("t4_cycle", cyc, 65);
    chk("t4_diven_cnt", cnt, 64);
    chk("t4_err", err, 1);
    chk("t4_y", y, 0);
    chk("t4_diven_off", div_en, 0);
    step();
    chk("t4_busy", busy, 0);

    // Serial angle, late div_ok, ignored start pulses
    ebits = 10'b1011001110;
    begin_op(12'd100, 12'd100, 12'd100);
    for (int unsigned k = 1; k <= 10; k++) begin
      e = ebits[10 - k];
      start = (k == 3);
      step();
    end
    e = 1'b0;
    start = 1'b0;
    wait_cycle(15);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_cycle(20);
    chk("t5_diven_c20", div_en, 1);
    chk("t5_mulen_c20", mul_en, 0);
    div_ok = 1'b1;
    step();
    div_ok = 1'b0;
    chk("t5_mulen_c21", mul_en, 1);
    chk("t5_sinin", sin_in, 10'h2CE);
    step();
    chk("t5_yv_c22", y_valid, 0);
    step();
    chk("t5_yv_c23", y_valid, 1);
    chk("t5_y", y, 14'h0555);
    step();
    chk("t5_busy", busy, 0);

    // Reset mid-operation
    begin_op(12'd100, 12'd100, 12'd100);
    wait_cycle(7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_y", y, 0);
    chk("t6_flags", {y_valid, err, div_en, mul_en}, 0);
    chk("t6_sinin", sin_in, 0);
    chk("t6_div", {div_dividend, div_divisor}, 0);
    chk("t6_mul", {mul_a, mul_b}, 0);
    cnt = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      step();
      if (y_valid || busy) cnt++;
    end
    chk("t6_quiet", cnt, 0);
    begin_op(12'd100, 12'd100, 12'd100);
    wait_cycle(5);
    div_ok = 1'b1;
    step();
    div_ok = 1'b0;
    wait_cycle(12);
    chk("t6_yv_c12", y_valid, 0);
    step();
    chk("t6_yv_c13", y_valid, 1);
    chk("t6_y2", y, 14'h0555);
    chk("t6_err2", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
